// File: rtl/extnet_stream_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// extnet_stream_ctrl_pkg
//   Shared constants, types and helpers for the CNN streaming front end.
//   Contents:
//     state_t      - frame controller state encoding
//     log2()       - ceil(log2(value)), never less than 1 so that derived
//                    counter widths stay legal even for degenerate values
//     RGB_CHANNELS - colour channels packed into one pixel word
// ----------------------------------------------------------------------------
package extnet_stream_ctrl_pkg;

    localparam int RGB_CHANNELS = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARM   = 2'd1,
        ST_RUN   = 2'd2,
        ST_FLUSH = 2'd3
    } state_t;

    // Smallest r with 2**r >= value, clamped to at least 1 bit.
    function automatic int log2(input int value);
        int r;
        r = 0;
        while (r < 31 && (32'sd1 <<< r) < value) begin
            r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/extnet_stream_ctrl_raster_counter.sv
// ----------------------------------------------------------------------------
// extnet_stream_ctrl_raster_counter
//   Free-running raster position generator covering the full window
//   (active area plus blanking). Advances every cycle from reset; never stalls.
//   Ports:
//     clock  - rising-edge clock
//     n_rst  - asynchronous active-low reset
//     cnt_v  - current row,    0 .. W_HEIGHT-1
//     cnt_h  - current column, 0 .. W_WIDTH-1
// ----------------------------------------------------------------------------
module extnet_stream_ctrl_raster_counter
    import extnet_stream_ctrl_pkg::*;
#(
    parameter  int W_HEIGHT = -1,
    parameter  int W_WIDTH  = -1,
    localparam int V_BITW   = log2(W_HEIGHT),
    localparam int H_BITW   = log2(W_WIDTH)
) (
    input  logic              clock,
    input  logic              n_rst,
    output logic [V_BITW-1:0] cnt_v,
    output logic [H_BITW-1:0] cnt_h
);

    localparam logic [V_BITW-1:0] V_LAST = V_BITW'(W_HEIGHT - 1);
    localparam logic [H_BITW-1:0] H_LAST = H_BITW'(W_WIDTH - 1);

    // NOTE: clocked state uses <= so every register samples pre-edge values,
    // independent of statement order inside the block.
    always_ff @(posedge clock or negedge n_rst) begin
        if (!n_rst) begin
            cnt_v <= '0;
            cnt_h <= '0;
        end else if (cnt_h == H_LAST) begin
            cnt_h <= '0;
            cnt_v <= (cnt_v == V_LAST) ? '0 : cnt_v + V_BITW'(1);
        end else begin
            cnt_h <= cnt_h + H_BITW'(1);
        end
    end

endmodule

// File: rtl/extnet_stream_ctrl.sv
// ----------------------------------------------------------------------------
// extnet_stream_ctrl
//   Frame controller feeding the extnet CNN. On request it waits for the next
//   raster origin, passes exactly one window of pixels (active area only) to
//   the network with row/column tags, then waits LATENCY cycles for the last
//   result to leave the network pipeline before reporting frame_done.
//   The raster never stalls: a missing pixel is replaced by 0 and flagged.
//   Ports:
//     clock, n_rst  - rising-edge clock, asynchronous active-low reset
//     start         - one-cycle frame request
//     in_valid      - upstream pixel valid
//     in_pixel      - upstream RGB pixel (3 x UINT_BITW)
//     in_ready      - pixel taken this cycle when in_valid && in_ready
//     out_y         - pixel to the network in_y port
//     out_vcnt      - row tag of out_y    (network in_vcnt)
//     out_hcnt      - column tag of out_y (network in_hcnt)
//     busy          - controller not idle
//     frame_done    - one-cycle pulse, last network output of the frame out
//     underflow     - sticky: an active pixel was starved during the frame
// ----------------------------------------------------------------------------
module extnet_stream_ctrl
    import extnet_stream_ctrl_pkg::*;
#(
    parameter  int HEIGHT    = -1,
    parameter  int WIDTH     = -1,
    parameter  int W_HEIGHT  = -1,
    parameter  int W_WIDTH   = -1,
    parameter  int UINT_BITW = -1,
    parameter  int LATENCY   = -1,
    localparam int V_BITW    = log2(W_HEIGHT),
    localparam int H_BITW    = log2(W_WIDTH),
    localparam int PIX_BITW  = (UINT_BITW > 0) ? UINT_BITW * RGB_CHANNELS : RGB_CHANNELS
) (
    input  logic                clock,
    input  logic                n_rst,
    input  logic                start,
    input  logic                in_valid,
    input  logic [PIX_BITW-1:0] in_pixel,
    output logic                in_ready,
    output logic [PIX_BITW-1:0] out_y,
    output logic [V_BITW-1:0]   out_vcnt,
    output logic [H_BITW-1:0]   out_hcnt,
    output logic                busy,
    output logic                frame_done,
    output logic                underflow
);

    localparam int F_BITW = log2(LATENCY);

    localparam logic [V_BITW-1:0] V_LAST   = V_BITW'(W_HEIGHT - 1);
    localparam logic [H_BITW-1:0] H_LAST   = H_BITW'(W_WIDTH - 1);
    localparam logic [V_BITW-1:0] V_ACTIVE = V_BITW'(HEIGHT);
    localparam logic [H_BITW-1:0] H_ACTIVE = H_BITW'(WIDTH);
    // Flush runs LATENCY cycles: the counter counts LATENCY-1 down to 0.
    localparam logic [F_BITW-1:0] F_LOAD   = F_BITW'(LATENCY - 1);

    logic [V_BITW-1:0] cnt_v;
    logic [H_BITW-1:0] cnt_h;

    state_t            state;
    state_t            state_next;
    logic [F_BITW-1:0] flush_cnt;
    logic [F_BITW-1:0] flush_cnt_next;
    logic              pending;
    logic              pending_next;
    logic              frame_done_next;
    logic              clear_underflow;
    logic              raster_last;

    extnet_stream_ctrl_raster_counter #(
        .W_HEIGHT (W_HEIGHT),
        .W_WIDTH  (W_WIDTH)
    ) u_raster (
        .clock (clock),
        .n_rst (n_rst),
        .cnt_v (cnt_v),
        .cnt_h (cnt_h)
    );

    // Last position of the window: the cycle before the raster returns to (0,0).
    assign raster_last = (cnt_v == V_LAST) && (cnt_h == H_LAST);

    assign in_ready = (state == ST_RUN) && (cnt_v < V_ACTIVE) && (cnt_h < H_ACTIVE);
    assign busy     = (state != ST_IDLE);

    // ------------------------------------------------------------------
    // Frame state machine
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge n_rst) begin
        if (!n_rst) begin
            state      <= ST_IDLE;
            flush_cnt  <= '0;
            pending    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_next;
            flush_cnt  <= flush_cnt_next;
            pending    <= pending_next;
            frame_done <= frame_done_next;
        end
    end

    // NOTE: every output of this block is given a default first, so no path
    // leaves a signal unassigned and no latch can be inferred.
    always_comb begin
        state_next      = state;
        flush_cnt_next  = flush_cnt;
        pending_next    = pending;
        frame_done_next = 1'b0;
        clear_underflow = 1'b0;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next      = ST_ARM;
                    clear_underflow = 1'b1;
                end
            end

            // Requests here are dropped: a frame is already on its way.
            ST_ARM: begin
                if (raster_last) begin
                    state_next = ST_RUN;
                end
            end

            ST_RUN: begin
                if (raster_last) begin
                    state_next     = ST_FLUSH;
                    flush_cnt_next = F_LOAD;
                end
            end

            ST_FLUSH: begin
                if (flush_cnt == '0) begin
                    frame_done_next = 1'b1;
                    pending_next    = 1'b0;
                    // A request arriving on the exit cycle itself still counts.
                    if (pending || start) begin
                        state_next      = ST_ARM;
                        clear_underflow = 1'b1;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end else begin
                    flush_cnt_next = flush_cnt - F_BITW'(1);
                    if (start) begin
                        pending_next = 1'b1;
                    end
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Pixel datapath: coordinates track the raster one cycle late so they
    // stay aligned with the registered pixel.
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge n_rst) begin
        if (!n_rst) begin
            out_y    <= '0;
            out_vcnt <= '0;
            out_hcnt <= '0;
        end else begin
            out_vcnt <= cnt_v;
            out_hcnt <= cnt_h;
            if (in_ready && in_valid) begin
                out_y <= in_pixel;
            end else begin
                out_y <= '0;
            end
        end
    end

    // Set and clear can never coincide: set needs RUN, clear needs IDLE/FLUSH.
    always_ff @(posedge clock or negedge n_rst) begin
        if (!n_rst) begin
            underflow <= 1'b0;
        end else if (clear_underflow) begin
            underflow <= 1'b0;
        end else if (in_ready && !in_valid) begin
            underflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_extnet_stream_ctrl.sv
// ----------------------------------------------------------------------------
// tb_extnet_stream_ctrl
//   Self-checking bench for extnet_stream_ctrl with a 6x4 window, 4x2 active
//   area and a 10-cycle network latency. The reference model describes each
//   frame by the absolute cycle at which its window starts; all expected
//   outputs follow from that with window arithmetic.
// ----------------------------------------------------------------------------
module tb_extnet_stream_ctrl;

    localparam int HEIGHT    = 2;
    localparam int WIDTH     = 4;
    localparam int W_HEIGHT  = 4;
    localparam int W_WIDTH   = 6;
    localparam int UINT_BITW = 8;
    localparam int LATENCY   = 10;
    localparam int WIN       = W_HEIGHT * W_WIDTH;   // cycles per window
    localparam int PIXW      = UINT_BITW * 3;

    logic            clock = 1'b0;
    logic            n_rst;
    logic            start;
    logic            in_valid;
    logic [PIXW-1:0] in_pixel;
    logic            in_ready;
    logic [PIXW-1:0] out_y;
    logic [1:0]      out_vcnt;
    logic [2:0]      out_hcnt;
    logic            busy;
    logic            frame_done;
    logic            underflow;

    extnet_stream_ctrl #(
        .HEIGHT    (HEIGHT),
        .WIDTH     (WIDTH),
        .W_HEIGHT  (W_HEIGHT),
        .W_WIDTH   (W_WIDTH),
        .UINT_BITW (UINT_BITW),
        .LATENCY   (LATENCY)
    ) dut (
        .clock      (clock),
        .n_rst      (n_rst),
        .start      (start),
        .in_valid   (in_valid),
        .in_pixel   (in_pixel),
        .in_ready   (in_ready),
        .out_y      (out_y),
        .out_vcnt   (out_vcnt),
        .out_hcnt   (out_hcnt),
        .busy       (busy),
        .frame_done (frame_done),
        .underflow  (underflow)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model. k counts cycles since reset release; the raster is
    // at position k mod WIN. A frame owns window [rs, rs+WIN) followed by
    // LATENCY flush cycles; frame_done is visible in cycle rs+WIN+LATENCY.
    // ------------------------------------------------------------------
    int        k;
    bit        have_frame;
    int        rs;
    int        busy_from;
    bit        pending_m;
    bit        uf_m;
    int        dut_hs;
    bit        ready_s;
    int        ready_k;

    function automatic bit m_ready(input int kk);
        int p;
        p = kk - rs;
        return have_frame && kk >= rs && kk < rs + WIN
               && (p / W_WIDTH) < HEIGHT && (p % W_WIDTH) < WIDTH;
    endfunction

    function automatic bit m_busy(input int kk);
        return have_frame && kk >= busy_from && kk <= rs + WIN + LATENCY - 1;
    endfunction

    task automatic model_reset();
        k          = 0;
        have_frame = 1'b0;
        rs         = 0;
        busy_from  = 0;
        pending_m  = 1'b0;
        uf_m       = 1'b0;
    endtask

    // One clock cycle: drive inputs at the falling edge, check in_ready,
    // advance the model across the rising edge, check registered outputs
    // at the next falling edge.
    task automatic cycle(input bit s, input bit v, input logic [PIXW-1:0] pix);
        bit              r;
        bit              exp_fd;
        logic [PIXW-1:0] exp_y;
        int              exp_v;
        int              exp_h;
        int              flush_end;

        start    = s;
        in_valid = v;
        in_pixel = pix;
        #1;
        r = m_ready(k);
        check("in_ready", {31'd0, in_ready}, {31'd0, r});
        ready_s = in_ready;
        ready_k = k;
        if (in_ready && in_valid) dut_hs++;

        exp_v  = (k % WIN) / W_WIDTH;
        exp_h  = k % W_WIDTH;
        exp_y  = (r && v) ? pix : '0;
        if (r && !v) uf_m = 1'b1;
        flush_end = rs + WIN + LATENCY - 1;
        exp_fd = have_frame && (k == flush_end);

        if (!m_busy(k)) begin
            if (s) begin
                have_frame = 1'b1;
                busy_from  = k + 1;
                rs         = ((k + 2 + WIN - 1) / WIN) * WIN;
                uf_m       = 1'b0;
            end
        end else if (k >= rs + WIN && k <= flush_end) begin
            if (s) pending_m = 1'b1;
            if (k == flush_end) begin
                if (pending_m) begin
                    busy_from = k + 1;
                    rs        = rs + 2 * WIN;
                    pending_m = 1'b0;
                    uf_m      = 1'b0;
                end else begin
                    have_frame = 1'b0;
                end
            end
        end

        @(posedge clock);
        k++;
        @(negedge clock);
        check("out_y",      out_y,                  exp_y);
        check("out_vcnt",   {30'd0, out_vcnt},      exp_v);
        check("out_hcnt",   {29'd0, out_hcnt},      exp_h);
        check("busy",       {31'd0, busy},          {31'd0, m_busy(k)});
        check("frame_done", {31'd0, frame_done},    {31'd0, exp_fd});
        check("underflow",  {31'd0, underflow},     {31'd0, uf_m});
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_out_y"},      out_y,               0);
        check({tag, "_out_vcnt"},   {30'd0, out_vcnt},   0);
        check({tag, "_out_hcnt"},   {29'd0, out_hcnt},   0);
        check({tag, "_busy"},       {31'd0, busy},       0);
        check({tag, "_frame_done"}, {31'd0, frame_done}, 0);
        check({tag, "_underflow"},  {31'd0, underflow},  0);
        check({tag, "_in_ready"},   {31'd0, in_ready},   0);
    endtask

    // ------------------------------------------------------------------
    // Directed table: idle raster right after reset.
    // ------------------------------------------------------------------
    typedef struct {
        bit              start;
        bit              valid;
        logic [PIXW-1:0] pix;
        logic [1:0]      exp_v;
        logic [2:0]      exp_h;
        bit              exp_busy;
    } vec_t;

    vec_t vecs[8];

    logic [PIXW-1:0] pix;
    bit              done;
    int              fd_k;
    int              fd_cnt;
    int              rdy_cnt;
    int              busy_cnt;
    int              hwraps;
    int              vwraps;
    logic [2:0]      prev_h;
    logic [1:0]      prev_v;

    initial begin
        vecs[0] = '{0, 1, 24'h111111, 2'd0, 3'd0, 0};
        vecs[1] = '{0, 1, 24'h222222, 2'd0, 3'd1, 0};
        vecs[2] = '{0, 0, 24'h333333, 2'd0, 3'd2, 0};
        vecs[3] = '{0, 1, 24'h444444, 2'd0, 3'd3, 0};
        vecs[4] = '{0, 1, 24'h555555, 2'd0, 3'd4, 0};
        vecs[5] = '{0, 0, 24'h666666, 2'd0, 3'd5, 0};
        vecs[6] = '{0, 1, 24'h777777, 2'd1, 3'd0, 0};
        vecs[7] = '{0, 1, 24'h888888, 2'd1, 3'd1, 0};

        n_rst    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_pixel = '0;
        dut_hs   = 0;
        pix      = 24'h000001;
        model_reset();
        repeat (3) @(negedge clock);
        check_all_zero("reset");
        n_rst = 1'b1;

        // Table: idle raster, no handshakes, coordinates step and wrap.
        for (int i = 0; i < 8; i++) begin
            cycle(vecs[i].start, vecs[i].valid, vecs[i].pix);
            check("tbl_vcnt",  {30'd0, out_vcnt}, {30'd0, vecs[i].exp_v});
            check("tbl_hcnt",  {29'd0, out_hcnt}, {29'd0, vecs[i].exp_h});
            check("tbl_busy",  {31'd0, busy},     {31'd0, vecs[i].exp_busy});
            check("tbl_out_y", out_y,             0);
        end

        // Full frame, valid always high, incrementing pixels.
        dut_hs = 0;
        cycle(1, 1, pix);
        pix++;
        done = 0;
        for (int i = 0; i < 120 && !done; i++) begin
            cycle(0, 1, pix);
            pix++;
            if (frame_done) done = 1;
        end
        check("frame1_done_seen",  {31'd0, done},      1);
        check("frame1_handshakes", dut_hs,             8);
        check("frame1_underflow",  {31'd0, underflow}, 0);

        // Starved pixel at (1,2).
        cycle(1, 1, pix);
        pix++;
        done = 0;
        for (int i = 0; i < 120 && !done; i++) begin
            cycle(0, (k % WIN) != 8, pix);
            if (ready_s && out_vcnt == 2'd1 && out_hcnt == 3'd2)
                check("starve_out_y", out_y, 0);
            pix++;
            if (frame_done) done = 1;
        end
        check("starve_done_seen",   {31'd0, done},      1);
        check("starve_uf_at_done",  {31'd0, underflow}, 1);

        // Next start clears underflow; starts during RUN and FLUSH.
        cycle(1, 1, pix);
        pix++;
        check("starve_uf_cleared", {31'd0, underflow}, 0);
        for (int i = 0; i < 100 && k != rs + 5; i++) begin
            cycle(0, 1, pix);
            pix++;
        end
        cycle(1, 1, pix);
        pix++;
        for (int i = 0; i < 100 && k != rs + WIN + 4; i++) begin
            cycle(0, 1, pix);
            pix++;
        end
        cycle(1, 1, pix);
        pix++;
        done = 0;
        for (int i = 0; i < 100 && !done; i++) begin
            cycle(0, 1, pix);
            pix++;
            if (frame_done) done = 1;
        end
        fd_k = k;
        check("pend_done_seen",      {31'd0, done}, 1);
        check("pend_busy_after_done", {31'd0, busy}, 1);
        done = 0;
        for (int i = 0; i < 100 && !done; i++) begin
            cycle(0, 1, pix);
            pix++;
            if (ready_s) done = 1;
        end
        check("pend_ready_seen", {31'd0, done}, 1);
        check("pend_gap_cycles", ready_k - fd_k, 14);
        done = 0;
        for (int i = 0; i < 100 && !done; i++) begin
            cycle(0, 1, pix);
            pix++;
            if (frame_done) done = 1;
        end
        check("pend_second_done", {31'd0, done}, 1);
        check("pend_idle_after",  {31'd0, busy}, 0);

        // Reset in RUN row 1.
        cycle(1, 1, pix);
        pix++;
        for (int i = 0; i < 100 && k != rs + 7; i++) begin
            cycle(0, 1, pix);
            pix++;
        end
        check("rst_in_run_busy", {31'd0, busy}, 1);
        #2;
        n_rst = 1'b0;
        #1;
        check_all_zero("midrst");
        @(negedge clock);
        @(negedge clock);
        check_all_zero("midrst_hold");
        n_rst = 1'b1;
        model_reset();
        fd_cnt = 0;
        for (int i = 0; i < 60; i++) begin
            cycle(0, 1, pix);
            pix++;
            if (frame_done) fd_cnt++;
        end
        check("midrst_no_done", fd_cnt, 0);

        // Three idle windows.
        rdy_cnt  = 0;
        busy_cnt = 0;
        hwraps   = 0;
        vwraps   = 0;
        prev_h   = out_hcnt;
        prev_v   = out_vcnt;
        for (int i = 0; i < 3 * WIN; i++) begin
            cycle(0, 1, pix);
            pix++;
            if (ready_s) rdy_cnt++;
            if (busy) busy_cnt++;
            if (prev_h == 3'd5 && out_hcnt == 3'd0) hwraps++;
            if (prev_v == 2'd3 && out_vcnt == 2'd0) vwraps++;
            prev_h = out_hcnt;
            prev_v = out_vcnt;
        end
        check("idle_ready_count", rdy_cnt,              0);
        check("idle_busy_count",  busy_cnt,             0);
        check("idle_hwrap_seen",  {31'd0, hwraps > 0},  1);
        check("idle_vwrap_seen",  {31'd0, vwraps > 0},  1);

        // Random traffic against the model.
        for (int i = 0; i < 800; i++) begin
            cycle($urandom_range(0, 19) == 0, $urandom_range(0, 9) != 0, PIXW'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/extnet_stream_ctrl.md
EXTNET_STREAM_CTRL -- requirements
Module: extnet_stream_ctrl

Interface
REQ-001 Parameter HEIGHT, default -1: active image rows.
REQ-002 Parameter WIDTH, default -1: active image columns.
REQ-003 Parameter W_HEIGHT, default -1: raster window rows including blanking; W_HEIGHT > HEIGHT.
REQ-004 Parameter W_WIDTH, default -1: raster window columns including blanking; W_WIDTH > WIDTH.
REQ-005 Parameter UINT_BITW, default -1: bits per colour channel.
REQ-006 Parameter LATENCY, default -1: network pipeline depth in cycles; must be >= 1.
REQ-007 Derived constants: V_BITW = ceil(log2(W_HEIGHT)); H_BITW = ceil(log2(W_WIDTH)).
REQ-008 Port clock, input, 1: single clock, rising edge.
REQ-009 Port n_rst, input, 1: reset, asynchronous, active-low.
REQ-010 Port start, input, 1: one-cycle frame request.
REQ-011 Port in_valid, input, 1: upstream pixel valid.
REQ-012 Port in_pixel, input, UINT_BITW*3: upstream RGB pixel.
REQ-013 Port in_ready, output, 1: pixel accepted when in_valid && in_ready.
REQ-014 Port out_y, output, UINT_BITW*3: pixel to network input.
REQ-015 Port out_vcnt, output, V_BITW: row coordinate paired with out_y.
REQ-016 Port out_hcnt, output, H_BITW: column coordinate paired with out_y.
REQ-017 Port busy, output, 1: high in every state except IDLE.
REQ-018 Port frame_done, output, 1: one-cycle pulse when the last network output of a frame has emerged.
REQ-019 Port underflow, output, 1: sticky; set on a starved active pixel.

Function
REQ-020 Internal raster counters cnt_h (0..W_WIDTH-1) and cnt_v (0..W_HEIGHT-1) shall run freely every cycle from reset: cnt_h wraps to 0 and increments cnt_v; cnt_v wraps to 0 after W_HEIGHT-1.
REQ-021 out_vcnt/out_hcnt shall be cnt_v/cnt_h registered one cycle, aligned with out_y.
REQ-022 The state machine shall have states IDLE, ARM, RUN, FLUSH.
REQ-023 IDLE: start -> ARM; underflow cleared on the same edge.
REQ-024 ARM: enter RUN on the cycle in which cnt_v==W_HEIGHT-1 and cnt_h==W_WIDTH-1, so RUN begins at (0,0).
REQ-025 RUN: lasts exactly one window; at (W_HEIGHT-1, W_WIDTH-1) -> FLUSH, with the flush counter loaded with LATENCY-1.
REQ-026 in_ready shall be combinational, high only when state==RUN, cnt_v<HEIGHT and cnt_h<WIDTH.
REQ-027 Accepted pixel: out_y <= in_pixel.
REQ-028 in_ready high with in_valid low: out_y <= 0 and underflow <= 1; the raster never stalls.
REQ-029 Outside the active RUN region: out_y <= 0.
REQ-030 FLUSH: decrement the flush counter each cycle; at 0 pulse frame_done for one cycle, then go to ARM if a start is pending, else IDLE.
REQ-031 start in ARM or RUN is ignored; start in FLUSH sets a one-deep pending flag, cleared on leaving FLUSH.
REQ-032 start coinciding with the FLUSH exit cycle counts as pending.
REQ-033 underflow persists until the next start accepted from IDLE, or a pending start consumed at FLUSH exit.

Reset
REQ-034 Asserting n_rst low shall asynchronously force: state IDLE; cnt_v, cnt_h, out_vcnt, out_hcnt, out_y, flush counter all 0; busy, frame_done, underflow, pending flag 0.
REQ-035 Reset mid-frame aborts the frame with no frame_done; the raster restarts at (0,0) on the first edge after release.

Structure
REQ-036 State encoding and the log2 function shall live in the shared CNN package/include with the other network constants.
REQ-037 One sub-module, raster_counter (cnt_v/cnt_h generation, parameters W_HEIGHT/W_WIDTH), is natural; the FSM and datapath stay in the top module.
REQ-038 Outputs shall connect directly to the extnet in_y/in_vcnt/in_hcnt ports without glue logic.

Verification (WIDTH=4, HEIGHT=2, W_WIDTH=6, W_HEIGHT=4, LATENCY=10, UINT_BITW=8)
REQ-039 Start in IDLE, in_valid always 1, incrementing pixels -> exactly 8 handshakes at rows 0-1, cols 0-3; out_y matches with one-cycle lag; frame_done 10 cycles after FLUSH entry; underflow=0.
REQ-040 in_valid dropped for the single active pixel (1,2) -> out_y=0 at out_vcnt=1, out_hcnt=2; underflow=1 and held through frame_done; cleared by the next start.
REQ-041 start during RUN -> ignored; start during FLUSH -> ARM immediately after frame_done, second frame begins at the next (0,0) with no idle window.
REQ-042 n_rst low at RUN row 1 -> all outputs 0 immediately; no frame_done; after release state IDLE and counters start at (0,0).
REQ-043 Run 3 windows idle -> out_hcnt wraps 5->0 and out_vcnt wraps 3->0; in_ready never asserted; busy=0.
